// File: rtl/liushui_d_if.sv
// Decode-stage bus for liushui_d: fetch inputs, writeback/MEM side ports,
// redirect/stall outputs and the registered ID/EX outputs.
interface liushui_d_if;
  logic [31:0] in_pc;
  logic [31:0] in_code;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [4:0]  mem_wa;
  logic        mem_load;
  logic [31:0] mem_data;
  logic        ifjump;
  logic [31:0] jumppc;
  logic        zuse;
  logic [31:0] e_pc;
  logic [31:0] e_code;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic [31:0] e_imm;
  logic [4:0]  e_wa;
  logic        e_load;

  modport master (
    output in_pc, in_code, wb_we, wb_addr, wb_data, wb_pc, mem_wa, mem_load, mem_data,
    input  ifjump, jumppc, zuse, e_pc, e_code, e_rs, e_rt, e_imm, e_wa, e_load
  );

  modport slave (
    input  in_pc, in_code, wb_we, wb_addr, wb_data, wb_pc, mem_wa, mem_load, mem_data,
    output ifjump, jumppc, zuse, e_pc, e_code, e_rs, e_rt, e_imm, e_wa, e_load
  );
endinterface

// File: rtl/liushui_d.sv
// MIPS-subset decode stage: register file, operand forwarding, hazard stall, branch resolve, ID/EX register.
// Optional macro RF_DISPLAY_EN prints every accepted register-file write.
module liushui_d (
  input  logic       clk,
  input  logic       reset,
  liushui_d_if.slave bus
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  // ---------------------------------------------------------------- register file
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (bus.wb_we && bus.wb_addr != 5'd0) begin
      rf_d[bus.wb_addr] = bus.wb_data;
    end
    rf_d[0] = 32'd0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (!reset) begin
        rf_q[i] <= 32'd0;
      end else begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

`ifdef RF_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (reset && bus.wb_we && bus.wb_addr != 5'd0) begin
      $display("@%h: $%0d <= %h", bus.wb_pc, bus.wb_addr, bus.wb_data);
    end
  end
`else
  logic unused_wb_pc;
  assign unused_wb_pc = ^bus.wb_pc;
`endif

  // Non-load MEM results win over a same-cycle WB write, which wins over the array.
  function automatic logic [31:0] fwd_value(
    input logic [4:0]  addr,
    input logic [4:0]  mem_wa,
    input logic        mem_load,
    input logic [31:0] mem_data,
    input logic        wb_we,
    input logic [4:0]  wb_addr,
    input logic [31:0] wb_data,
    input logic [31:0] rf_val
  );
    logic [31:0] val;
    if (addr == 5'd0) begin
      val = 32'd0;
    end else if (mem_wa == addr && !mem_load) begin
      val = mem_data;
    end else if (wb_we && wb_addr == addr) begin
      val = wb_data;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  // ---------------------------------------------------------------- decode
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [4:0]  rd_a;
  logic [15:0] imm16;
  logic [25:0] idx26;

  assign op    = bus.in_code[31:26];
  assign rs_a  = bus.in_code[25:21];
  assign rt_a  = bus.in_code[20:16];
  assign rd_a  = bus.in_code[15:11];
  assign funct = bus.in_code[5:0];
  assign imm16 = bus.in_code[15:0];
  assign idx26 = bus.in_code[25:0];

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_bne, is_j, is_jal;
  logic use_rs, use_rt, is_ctrl;

  always_comb begin
    is_addu = (op == OP_SPECIAL) && (funct == FN_ADDU);
    is_subu = (op == OP_SPECIAL) && (funct == FN_SUBU);
    is_jr   = (op == OP_SPECIAL) && (funct == FN_JR);
    is_ori  = (op == OP_ORI);
    is_lui  = (op == OP_LUI);
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_beq  = (op == OP_BEQ);
    is_bne  = (op == OP_BNE);
    is_j    = (op == OP_J);
    is_jal  = (op == OP_JAL);
    use_rs  = is_addu | is_subu | is_ori | is_lw | is_sw | is_beq | is_bne | is_jr;
    use_rt  = is_addu | is_subu | is_sw | is_beq | is_bne;
    is_ctrl = is_beq | is_bne | is_jr;
  end

  logic [31:0] rs_val;
  logic [31:0] rt_val;

  always_comb begin
    rs_val = 32'd0;
    rt_val = 32'd0;
    if (use_rs) begin
      rs_val = fwd_value(rs_a, bus.mem_wa, bus.mem_load, bus.mem_data,
                         bus.wb_we, bus.wb_addr, bus.wb_data, rf_q[rs_a]);
    end
    if (use_rt) begin
      rt_val = fwd_value(rt_a, bus.mem_wa, bus.mem_load, bus.mem_data,
                         bus.wb_we, bus.wb_addr, bus.wb_data, rf_q[rt_a]);
    end
  end

  // ---------------------------------------------------------------- hazards
  logic [31:0] e_pc_q, e_code_q, e_rs_q, e_rt_q, e_imm_q;
  logic [4:0]  e_wa_q;
  logic        e_load_q;
  logic        ex_hit, mem_ld_hit, stall;

  always_comb begin
    ex_hit     = (e_wa_q != 5'd0) &&
                 ((use_rs && rs_a == e_wa_q) || (use_rt && rt_a == e_wa_q));
    mem_ld_hit = (bus.mem_wa != 5'd0) && bus.mem_load &&
                 ((use_rs && rs_a == bus.mem_wa) || (use_rt && rt_a == bus.mem_wa));
    // Control ops resolve here, so they must wait for any in-flight producer.
    stall      = (ex_hit && (e_load_q || is_ctrl)) || (is_ctrl && mem_ld_hit);
  end

  // ---------------------------------------------------------------- control resolve
  logic [31:0] pc4, simm, branch_pc, jump_pc;
  logic        take;

  always_comb begin
    pc4       = bus.in_pc + 32'd4;
    simm      = {{16{imm16[15]}}, imm16};
    branch_pc = pc4 + {simm[29:0], 2'b00};
    jump_pc   = {pc4[31:28], idx26, 2'b00};
    take      = is_j | is_jal | is_jr |
                (is_beq && rs_val == rt_val) | (is_bne && rs_val != rt_val);
    bus.zuse   = reset && stall;
    bus.ifjump = reset && !stall && take;
    if (is_jr) begin
      bus.jumppc = rs_val;
    end else if (is_j || is_jal) begin
      bus.jumppc = jump_pc;
    end else begin
      bus.jumppc = branch_pc;
    end
  end

  // ---------------------------------------------------------------- ID/EX register
  logic [31:0] e_pc_d, e_code_d, e_rs_d, e_rt_d, e_imm_d;
  logic [4:0]  e_wa_d;
  logic        e_load_d;

  always_comb begin
    e_pc_d   = 32'd0;
    e_code_d = 32'd0;
    e_rs_d   = 32'd0;
    e_rt_d   = 32'd0;
    e_imm_d  = 32'd0;
    e_wa_d   = 5'd0;
    e_load_d = 1'b0;
    if (!stall) begin
      e_pc_d   = bus.in_pc;
      e_code_d = bus.in_code;
      e_rs_d   = rs_val;
      e_rt_d   = rt_val;
      e_load_d = is_lw;
      if (is_ori) begin
        e_imm_d = {16'h0000, imm16};
      end else if (is_lw || is_sw || is_beq || is_bne) begin
        e_imm_d = simm;
      end else if (is_lui) begin
        e_imm_d = {imm16, 16'h0000};
      end
      if (is_addu || is_subu) begin
        e_wa_d = rd_a;
      end else if (is_ori || is_lui || is_lw) begin
        e_wa_d = rt_a;
      end else if (is_jal) begin
        e_wa_d = 5'd31;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_pc_q   <= 32'd0;
      e_code_q <= 32'd0;
      e_rs_q   <= 32'd0;
      e_rt_q   <= 32'd0;
      e_imm_q  <= 32'd0;
      e_wa_q   <= 5'd0;
      e_load_q <= 1'b0;
    end else begin
      e_pc_q   <= e_pc_d;
      e_code_q <= e_code_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_imm_q  <= e_imm_d;
      e_wa_q   <= e_wa_d;
      e_load_q <= e_load_d;
    end
  end

  assign bus.e_pc   = e_pc_q;
  assign bus.e_code = e_code_q;
  assign bus.e_rs   = e_rs_q;
  assign bus.e_rt   = e_rt_q;
  assign bus.e_imm  = e_imm_q;
  assign bus.e_wa   = e_wa_q;
  assign bus.e_load = e_load_q;

endmodule

// File: tb/tb_liushui_d.sv
// Scoreboard bench for liushui_d: expected ID/EX contents are queued when an
// instruction is presented and compared one edge later; redirect/stall checked combinationally.
module tb_liushui_d;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  liushui_d_if bus ();

  liushui_d dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] code;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  wa;
    logic        load;
  } ex_t;

  ex_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ex_t mk(input logic [31:0] pc, input logic [31:0] code,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] imm, input logic [4:0] wa, input logic load);
    ex_t e;
    e.pc = pc; e.code = code; e.rs = rs; e.rt = rt; e.imm = imm; e.wa = wa; e.load = load;
    return e;
  endfunction

  function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic side(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] mwa, input logic ml, input logic [31:0] md);
    bus.wb_we    = we;
    bus.wb_addr  = wa;
    bus.wb_data  = wd;
    bus.wb_pc    = 32'h0000_3000;
    bus.mem_wa   = mwa;
    bus.mem_load = ml;
    bus.mem_data = md;
  endtask

  task automatic issue(input string name, input logic [31:0] pc, input logic [31:0] code,
                       input logic exp_zuse, input logic exp_jmp, input logic [31:0] exp_jpc,
                       input ex_t e);
    ex_t bubble;
    ex_t x;
    bubble = mk(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    bus.in_pc   = pc;
    bus.in_code = code;
    #1;
    $display("%s pc=%h code=%h zuse=%0d ifjump=%0d jumppc=%h",
             name, pc, code, bus.zuse, bus.ifjump, bus.jumppc);
    chk({name, ".zuse"}, 32'(bus.zuse), 32'(exp_zuse));
    chk({name, ".ifjump"}, 32'(bus.ifjump), 32'(exp_jmp));
    if (exp_jmp) chk({name, ".jumppc"}, bus.jumppc, exp_jpc);
    exp_q.push_back(exp_zuse ? bubble : e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({name, ".queue"}, 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      chk({name, ".e_pc"},   bus.e_pc,   x.pc);
      chk({name, ".e_code"}, bus.e_code, x.code);
      chk({name, ".e_rs"},   bus.e_rs,   x.rs);
      chk({name, ".e_rt"},   bus.e_rt,   x.rt);
      chk({name, ".e_imm"},  bus.e_imm,  x.imm);
      chk({name, ".e_wa"},   32'(bus.e_wa),   32'(x.wa));
      chk({name, ".e_load"}, 32'(bus.e_load), 32'(x.load));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    reset = 1'b0;
    bus.in_pc = 32'd0;
    bus.in_code = 32'd0;
    // A write attempted during reset must be dropped.
    side(1'b1, 5'd1, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.e_pc",   bus.e_pc,   32'd0);
    chk("rst.e_code", bus.e_code, 32'd0);
    chk("rst.e_rs",   bus.e_rs,   32'd0);
    chk("rst.e_rt",   bus.e_rt,   32'd0);
    chk("rst.e_imm",  bus.e_imm,  32'd0);
    chk("rst.e_wa",   32'(bus.e_wa),   32'd0);
    chk("rst.e_load", 32'(bus.e_load), 32'd0);
    chk("rst.zuse",   32'(bus.zuse),   32'd0);
    chk("rst.ifjump", 32'(bus.ifjump), 32'd0);
    reset = 1'b1;
    side(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);

    c = r_op(5'd1, 5'd0, 5'd20, 6'h21);
    issue("rst_wr_drop", 32'h3000, c, 0, 0, 0, mk(32'h3000, c, 0, 0, 0, 5'd20, 0));

    side(1'b1, 5'd1, 32'd5, 5'd0, 1'b0, 32'd0);
    issue("wb_r1", 32'h3004, 32'd0, 0, 0, 0, mk(32'h3004, 0, 0, 0, 0, 5'd0, 0));
    side(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    c = i_op(6'h0D, 5'd1, 5'd2, 16'h0010);
    issue("ori", 32'h3008, c, 0, 0, 0, mk(32'h3008, c, 32'd5, 0, 32'h10, 5'd2, 0));

    side(1'b1, 5'd5, 32'd7, 5'd0, 1'b0, 32'd0);
    issue("wb_r5", 32'h300C, 32'd0, 0, 0, 0, mk(32'h300C, 0, 0, 0, 0, 5'd0, 0));
    side(1'b1, 5'd6, 32'd7, 5'd0, 1'b0, 32'd0);
    issue("wb_r6", 32'h3010, 32'd0, 0, 0, 0, mk(32'h3010, 0, 0, 0, 0, 5'd0, 0));

    side(1'b1, 5'd8, 32'h1234, 5'd0, 1'b0, 32'd0);
    c = r_op(5'd8, 5'd0, 5'd9, 6'h21);
    issue("wb_thru", 32'h3014, c, 0, 0, 0, mk(32'h3014, c, 32'h1234, 0, 0, 5'd9, 0));

    side(1'b1, 5'd8, 32'hBBBB, 5'd8, 1'b0, 32'hAAAA);
    c = r_op(5'd8, 5'd8, 5'd9, 6'h21);
    issue("mem_prio", 32'h3018, c, 0, 0, 0, mk(32'h3018, c, 32'hAAAA, 32'hAAAA, 0, 5'd9, 0));
    side(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);

    c = r_op(5'd8, 5'd1, 5'd10, 6'h23);
    issue("subu_rf", 32'h301C, c, 0, 0, 0, mk(32'h301C, c, 32'hBBBB, 32'd5, 0, 5'd10, 0));

    c = i_op(6'h04, 5'd5, 5'd6, 16'd3);
    issue("beq_taken", 32'h3000, c, 0, 1, 32'h3010, mk(32'h3000, c, 7, 7, 3, 5'd0, 0));
    c = i_op(6'h05, 5'd5, 5'd6, 16'd3);
    issue("bne_not", 32'h3000, c, 0, 0, 0, mk(32'h3000, c, 7, 7, 3, 5'd0, 0));
    c = i_op(6'h05, 5'd5, 5'd1, 16'hFFFE);
    issue("bne_back", 32'h3100, c, 0, 1, 32'h30FC, mk(32'h3100, c, 7, 5, 32'hFFFF_FFFE, 5'd0, 0));

    c = j_op(6'h03, 26'h0C01);
    issue("jal", 32'h3004, c, 0, 1, 32'h3004, mk(32'h3004, c, 0, 0, 0, 5'd31, 0));
    c = j_op(6'h02, 26'h100);
    issue("j_region", 32'h4000_0010, c, 0, 1, 32'h4000_0400, mk(32'h4000_0010, c, 0, 0, 0, 5'd0, 0));

    c = i_op(6'h23, 5'd1, 5'd3, 16'd4);
    issue("lw", 32'h3010, c, 0, 0, 0, mk(32'h3010, c, 5, 0, 4, 5'd3, 1));
    side(1'b0, 5'd0, 32'd0, 5'd3, 1'b1, 32'd0);
    c = r_op(5'd3, 5'd3, 5'd4, 6'h21);
    issue("ld_use_stall", 32'h3014, c, 1, 0, 0, mk(32'h3014, c, 0, 0, 0, 5'd4, 0));
    side(1'b1, 5'd3, 32'h55, 5'd0, 1'b0, 32'd0);
    issue("ld_use_go", 32'h3014, c, 0, 0, 0, mk(32'h3014, c, 32'h55, 32'h55, 0, 5'd4, 0));
    side(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);

    c = r_op(5'd5, 5'd6, 5'd7, 6'h21);
    issue("addu_r7", 32'h3018, c, 0, 0, 0, mk(32'h3018, c, 7, 7, 0, 5'd7, 0));
    c = r_op(5'd7, 5'd0, 5'd0, 6'h08);
    issue("jr_stall", 32'h301C, c, 1, 0, 0, mk(32'h301C, c, 0, 0, 0, 5'd0, 0));
    side(1'b0, 5'd0, 32'd0, 5'd7, 1'b0, 32'd14);
    issue("jr_go", 32'h301C, c, 0, 1, 32'd14, mk(32'h301C, c, 32'd14, 0, 0, 5'd0, 0));

    side(1'b0, 5'd0, 32'd0, 5'd5, 1'b1, 32'd0);
    c = i_op(6'h04, 5'd5, 5'd6, 16'd3);
    issue("beq_memld", 32'h3020, c, 1, 0, 0, mk(32'h3020, c, 0, 0, 0, 5'd0, 0));
    side(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);

    c = i_op(6'h2B, 5'd5, 5'd6, 16'd8);
    issue("sw", 32'h3024, c, 0, 0, 0, mk(32'h3024, c, 7, 7, 8, 5'd0, 0));
    c = i_op(6'h23, 5'd0, 5'd12, 16'd0);
    issue("lw_r12", 32'h3028, c, 0, 0, 0, mk(32'h3028, c, 0, 0, 0, 5'd12, 1));
    c = i_op(6'h0F, 5'd12, 5'd13, 16'h1234);
    issue("lui_nors", 32'h302C, c, 0, 0, 0, mk(32'h302C, c, 0, 0, 32'h1234_0000, 5'd13, 0));
    c = 32'hFC00_0000;
    issue("nop_op", 32'h3030, c, 0, 0, 0, mk(32'h3030, c, 0, 0, 0, 5'd0, 0));
    c = r_op(5'd1, 5'd2, 5'd3, 6'h20);
    issue("nop_add", 32'h3034, c, 0, 0, 0, mk(32'h3034, c, 0, 0, 0, 5'd0, 0));

    c = i_op(6'h23, 5'd1, 5'd15, 16'd0);
    issue("lw_r15", 32'h3038, c, 0, 0, 0, mk(32'h3038, c, 5, 0, 0, 5'd15, 1));
    reset = 1'b0;
    c = r_op(5'd15, 5'd1, 5'd16, 6'h21);
    issue("rst_in_stall", 32'h303C, c, 0, 0, 0, mk(32'd0, 32'd0, 0, 0, 0, 5'd0, 0));
    reset = 1'b1;

    c = r_op(5'd1, 5'd5, 5'd17, 6'h21);
    issue("rf_clr_a", 32'h3040, c, 0, 0, 0, mk(32'h3040, c, 0, 0, 0, 5'd17, 0));
    c = r_op(5'd6, 5'd8, 5'd18, 6'h23);
    issue("rf_clr_b", 32'h3044, c, 0, 0, 0, mk(32'h3044, c, 0, 0, 0, 5'd18, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/liushui_d.md
LIUSHUI_D -- requirements
Module: liushui_d

Interface
REQ-001 SHALL: clk  in  1  sole clock, all state updates on posedge.
REQ-002 SHALL: reset  in  1  synchronous, active-low; reset==0 at a posedge clears all state.
REQ-003 SHALL: in_pc  in  32  PC of instruction in decode (driven by fetch npc).
REQ-004 SHALL: in_code  in  32  instruction word in decode (driven by fetch ncode).
REQ-005 SHALL: wb_we, wb_addr[4:0], wb_data[31:0], wb_pc[31:0]  in  writeback port into register file.
REQ-006 SHALL: mem_wa[4:0], mem_load, mem_data[31:0]  in  MEM-stage destination, load flag, ALU result.
REQ-007 SHALL: ifjump  out  1  redirect request to fetch; jumppc  out  32  redirect target.
REQ-008 SHALL: zuse  out  1  stall request to fetch (fetch holds PC while 1).
REQ-009 SHALL: e_pc, e_code, e_rs, e_rt, e_imm  out  32 each; e_wa  out  5; e_load  out  1 -- registered ID/EX outputs.

Function
REQ-010 SHALL decode addu, subu, ori, lui, lw, sw, beq, bne, j, jal, jr; every other word is treated as nop (no reads, no writes, no redirect).
REQ-011 SHALL hold a 32x32 register file; $0 reads 0 and ignores writes; write at posedge when reset==1, wb_we==1, wb_addr!=0.
REQ-012 SHALL forward operands combinationally, priority: MEM stage (mem_wa==addr, addr!=0, mem_load==0) > same-cycle WB write (write-through) > register file.
REQ-013 SHALL extend imm: ori zero-extend; lw/sw/beq/bne sign-extend; lui {imm16,16'h0}; e_imm=0 otherwise.
REQ-014 SHALL set e_wa: rd for addu/subu; rt for ori/lui/lw; 31 for jal; 0 otherwise. e_load=1 only for lw.
REQ-015 SHALL resolve control in ID, combinationally: beq taken if rs==rt, bne if rs!=rt, target in_pc+4+(simm<<2); j/jal target {in_pc+4 [31:28], idx26, 2'b00}; jr target rs value; ifjump=1 for j, jal, jr, and taken branches.
REQ-016 SHALL assert zuse when in ID: (a) an operand read matches EX dest (e_wa!=0) and e_load==1; (b) beq/bne/jr reads an EX dest e_wa!=0 (any type); (c) beq/bne/jr reads MEM dest mem_wa!=0 with mem_load==1.
REQ-017 SHALL force ifjump=0 whenever zuse=1 (no redirect on stale operands).
REQ-018 SHALL, on a posedge with zuse=1, load a bubble into ID/EX (all e_* = 0); otherwise latch decoded values; latency ID->EX one cycle.
REQ-019 SHALL not flush the delay-slot instruction: instruction fetched after a branch/jump proceeds normally.
REQ-020 SHALL treat rs/rt fields as unused (no stall, no forward) for instructions that do not read them.

Reset
REQ-021 SHALL, on reset==0 at posedge, clear all 32 registers and all e_* outputs to 0.
REQ-022 SHALL hold ifjump=0 and zuse=0 while reset==0; reset mid-stall drops the stall at the same edge.
REQ-023 SHALL ignore wb_we during reset (reset wins over write).

Configuration
REQ-024 SHALL, when RF_DISPLAY_EN is defined, print "@<wb_pc hex>: $<wb_addr dec> <= <wb_data hex>" on every accepted register write (addr!=0); when undefined, no display code and identical functional behaviour.

Verification
REQ-025 SHALL: wb write $1<=5, then in_code ori $2,$1,0x10 -> e_rs=5, e_imm=0x10, e_wa=2 one cycle later.
REQ-026 SHALL: lw $3 in EX, addu $4,$3,$3 in ID -> zuse=1 one cycle, e_* bubble 0, addu issues next cycle with MEM/WB-forwarded $3.
REQ-027 SHALL: $5=$6=7, beq $5,$6,+3 at in_pc 0x3000 -> ifjump=1, jumppc=0x3010; bne same -> ifjump=0.
REQ-028 SHALL: jal 0x0C01 at 0x3004 -> jumppc=0x3004+... {0x0,0x0C01,00}=0x00003004, e_wa=31, e_pc=0x3004.
REQ-029 SHALL: addu $7 in EX, jr $7 in ID -> zuse=1, ifjump=0; next cycle MEM-forwarded target, ifjump=1.
REQ-030 SHALL: reset=0 during stall with nonzero registers -> all e_*=0, zuse=0, $1..$31 read 0 after edge.
